async_chan_tx: RTL and testbench

- Clocked transmitter that drives one two-phase bundled-data channel (req/ack/dat) into the self-timed latch pipeline.
- It is the initiating end of the channel that the pipeline's input latch responds to.
- Accepts words on a synchronous valid/ready interface and buffers them in a small FIFO.
- Issues each word as one token: dat first, then a req transition after a programmable bundling delay; it waits for the matching ack transition before issuing the next token.

---
 rtl/async_chan_tx.sv | 148 ++++++++++++++
 tb/tb_async_chan_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_chan_tx.sv
// async_chan_tx: clocked initiator of a two-phase bundled-data channel.
// Words are queued in a small FIFO and issued as req/ack tokens.
module async_chan_tx #(
  parameter int DW          = 1,
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TO_CYC      = 1024,
  parameter int CW          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          req_o,
  input  logic          ack_i,
  output logic [DW-1:0] dat_o,
  output logic          busy,
  output logic [CW-1:0] tokens_sent,
  output logic          timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = $clog2(SETUP_CYC + 1);
  localparam int TW = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [DW-1:0]    mem_q [DEPTH];
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             req_q, req_d;
  logic [DW-1:0]    dat_q, dat_d;
  logic [CW-1:0]    tok_q, tok_d;
  logic             to_q, to_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic          ack_s;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          outstanding;
  logic [DW-1:0] head;

  assign ack_s = sync_q[SYNC_STAGES-1];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = in_valid && !full;
  assign head  = mem_q[rptr_q[AW-1:0]];
  assign outstanding = (req_q != ack_s);

  assign in_ready    = !full;
  assign req_o       = req_q;
  assign dat_o       = dat_q;
  assign tokens_sent = tok_q;
  assign timeout     = to_q;
  assign busy        = !empty || (state_q != IDLE);

  // Next-state for synchronizer, FIFO pointers and token FSM.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], ack_i};
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    req_d   = req_q;
    dat_d   = dat_q;
    tok_d   = tok_q;
    to_d    = to_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !outstanding) begin
          dat_d   = head;
          pop     = 1'b1;
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == NW'(SETUP_CYC - 1)) begin
          req_d   = ~req_q;
          tcnt_d  = '0;
          state_d = WAIT_ACK;
        end else begin
          cnt_d = cnt_q + NW'(1);
        end
      end
      WAIT_ACK: begin
        if (ack_s == req_q) begin
          tok_d   = tok_q + CW'(1);
          state_d = IDLE;
        end else if (tcnt_q >= TW'(TO_CYC - 1)) begin
          to_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
  end

  // FIFO storage; contents need no reset, pointers define validity.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wptr_q[AW-1:0]] <= in_data;
    end
  end

  // Register all control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      req_q   <= 1'b0;
      dat_q   <= '0;
      tok_q   <= '0;
      to_q    <= 1'b0;
      sync_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      req_q   <= req_d;
      dat_q   <= dat_d;
      tok_q   <= tok_d;
      to_q    <= to_d;
      sync_q  <= sync_d;
    end
  end

endmodule

// File: tb/tb_async_chan_tx.sv
// tb_async_chan_tx: directed bench for async_chan_tx.
// Plays the async pipeline's input latch by toggling ack_i.
module tb_async_chan_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:0]  in_data;
  logic        req_o;
  logic        ack_i;
  logic [0:0]  dat_o;
  logic        busy;
  logic [15:0] tokens_sent;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;
  int dat_bad = 0;

  async_chan_tx #(
    .DW(1), .DEPTH(4), .SETUP_CYC(2),
    .SYNC_STAGES(2), .TO_CYC(16), .CW(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .req_o(req_o),
    .ack_i(ack_i), .dat_o(dat_o), .busy(busy),
    .tokens_sent(tokens_sent), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_mon(int n, logic exp);
    repeat (n) begin
      step(1);
      if (dat_o !== exp) dat_bad++;
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ack_i    = 1'b0;
    in_valid = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic push(logic w);
    int  n;
    logic ok;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    do begin
      ok = in_ready;
      step(1);
      n++;
    end while (!ok && n < 100);
    chk("push_wait", 32'(ok), 32'd1);
  endtask

  task automatic respond(int cnt, logic [7:0] exp);
    int n;
    for (int k = 0; k < cnt; k++) begin
      n = 0;
      while (req_o === ack_i && n < 60) begin
        step(1);
        n++;
      end
      chk("req_seen", 32'(n < 60), 32'd1);
      chk("tok_dat", 32'(dat_o), 32'(exp[k]));
      if (k == 1) chk("ready_after_pop", 32'(in_ready), 32'd1);
      step(2);
      ack_i = ~ack_i;
    end
  endtask

  task automatic wait_tok(logic [15:0] want);
    int n;
    n = 0;
    while (tokens_sent !== want && n < 20) begin
      step(1);
      n++;
    end
    chk("tok_wait", 32'(tokens_sent), 32'(want));
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 1'b1;
    ack_i    = 1'b0;

    // reset with in_valid held high
    step(1);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_tok", 32'(tokens_sent), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_to", 32'(timeout), 32'd0);
    step(2);
    chk("rst_busy2", 32'(busy), 32'd0);
    chk("rst_ready2", 32'(in_ready), 32'd1);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // single word with latency check
    in_valid = 1'b1;
    in_data  = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(1);
    chk("e1_dat", 32'(dat_o), 32'd1);
    chk("e1_req", 32'(req_o), 32'd0);
    chk("e1_busy", 32'(busy), 32'd1);
    step_mon(1, 1'b1);
    chk("e2_req", 32'(req_o), 32'd0);
    step_mon(1, 1'b1);
    chk("e3_req", 32'(req_o), 32'd1);
    step_mon(3, 1'b1);
    ack_i = 1'b1;
    n = 0;
    while (tokens_sent !== 16'd1 && n < 6) begin
      step_mon(1, 1'b1);
      n++;
    end
    chk("ack_lat", 32'(n <= 3), 32'd1);
    chk("tok1", 32'(tokens_sent), 32'd1);
    chk("dat_stable", 32'(dat_bad), 32'd0);
    step(1);
    chk("idle_busy", 32'(busy), 32'd0);

    // five words back to back, responder stalled
    do_reset();
    push(1'b1);
    push(1'b0);
    push(1'b1);
    push(1'b1);
    push(1'b0);
    in_valid = 1'b0;
    step(2);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    chk("stall_req", 32'(req_o), 32'd1);
    chk("stall_tok", 32'(tokens_sent), 32'd0);
    respond(5, 8'b0000_1101);
    wait_tok(16'd5);
    chk("burst_req", 32'(req_o), 32'd1);
    step(1);
    chk("burst_busy", 32'(busy), 32'd0);
    chk("burst_ready", 32'(in_ready), 32'd1);

    // timeout with a silent responder
    do_reset();
    in_valid = 1'b1;
    in_data  = 1'b1;
    step(1);
    in_valid = 1'b0;
    step(3);
    chk("to_req", 32'(req_o), 32'd1);
    step(15);
    chk("to_e18", 32'(timeout), 32'd0);
    step(1);
    chk("to_e19", 32'(timeout), 32'd1);
    step(4);
    chk("to_held", 32'(timeout), 32'd1);
    chk("to_waiting", 32'(busy), 32'd1);
    ack_i = 1'b1;
    wait_tok(16'd1);
    chk("to_sticky", 32'(timeout), 32'd1);
    step(1);
    chk("to_idle", 32'(busy), 32'd0);

    // spurious ack while idle and empty
    ack_i = 1'b0;
    step(6);
    chk("sp_tok", 32'(tokens_sent), 32'd1);
    chk("sp_req", 32'(req_o), 32'd1);
    chk("sp_busy", 32'(busy), 32'd0);
    chk("sp_dat", 32'(dat_o), 32'd1);
    chk("sp_to", 32'(timeout), 32'd1);

    // reset while waiting for ack with two words queued
    do_reset();
    push(1'b0);
    push(1'b1);
    push(1'b1);
    in_valid = 1'b0;
    step(2);
    chk("rw_req", 32'(req_o), 32'd1);
    chk("rw_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    ack_i = 1'b0;
    step(1);
    chk("rw_ready", 32'(in_ready), 32'd1);
    chk("rw_busy0", 32'(busy), 32'd0);
    chk("rw_req0", 32'(req_o), 32'd0);
    chk("rw_tok0", 32'(tokens_sent), 32'd0);
    chk("rw_to0", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step(3);
    chk("rw_empty", 32'(busy), 32'd0);
    push(1'b1);
    in_valid = 1'b0;
    respond(1, 8'b0000_0001);
    wait_tok(16'd1);
    chk("rw_req1", 32'(req_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
